// File: rtl/ga_pkg.sv
// Shared GA pipeline constants and the fitness-evaluator FSM state type.
// Used by the population, fitness and selection stages.
package ga_pkg;

  localparam int unsigned POP_SIZE    = 100;
  localparam int unsigned GENOME_BITS = 75;
  localparam int unsigned CHUNK_BITS  = 25;
  localparam int unsigned IDX_W       = $clog2(POP_SIZE);
  localparam int unsigned SCORE_W     = $clog2(GENOME_BITS + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_ACCUM = 3'd2,
    ST_EMIT  = 3'd3,
    ST_DONE  = 3'd4
  } fit_state_t;

endpackage

// File: rtl/popcount_chunk.sv
// Combinational population count of one genome chunk.
module popcount_chunk #(
  parameter int unsigned CHUNK_BITS = 25
) (
  input  logic [CHUNK_BITS-1:0]           bits,
  output logic [$clog2(CHUNK_BITS+1)-1:0] count
);

  localparam int unsigned CNT_W = $clog2(CHUNK_BITS + 1);

  always_comb begin
    logic [CNT_W-1:0] sum;
    sum = '0;
    for (int unsigned i = 0; i < CHUNK_BITS; i++) begin
      sum = sum + CNT_W'(bits[i]);
    end
    count = sum;
  end

endmodule

// File: rtl/pop_fitness_eval.sv
// Scores every genome of a population snapshot against a target pattern,
// streams the scores over valid/ready and tracks the fittest individual.
module pop_fitness_eval
  import ga_pkg::*;
#(
  parameter int unsigned POP_SIZE    = ga_pkg::POP_SIZE,
  parameter int unsigned GENOME_BITS = ga_pkg::GENOME_BITS,
  parameter int unsigned CHUNK_BITS  = ga_pkg::CHUNK_BITS
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [POP_SIZE*GENOME_BITS-1:0]   population,
  input  logic [GENOME_BITS-1:0]            target,
  output logic                              score_valid,
  input  logic                              score_ready,
  output logic [$clog2(POP_SIZE)-1:0]       score_index,
  output logic [$clog2(GENOME_BITS+1)-1:0]  score_value,
  output logic [$clog2(POP_SIZE)-1:0]       best_index,
  output logic [$clog2(GENOME_BITS+1)-1:0]  best_value,
  output logic                              busy,
  output logic                              done
);

  localparam int unsigned NCHUNK  = GENOME_BITS / CHUNK_BITS;
  localparam int unsigned IDX_W   = $clog2(POP_SIZE);
  localparam int unsigned SCORE_W = $clog2(GENOME_BITS + 1);
  localparam int unsigned PC_W    = $clog2(CHUNK_BITS + 1);
  localparam int unsigned CHUNK_W = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int unsigned SNAP_W  = POP_SIZE * GENOME_BITS;

  if (GENOME_BITS % CHUNK_BITS != 0) begin : g_bad_chunk
    $error("GENOME_BITS must be a multiple of CHUNK_BITS");
  end

  fit_state_t state, state_nxt;

  logic [SNAP_W-1:0]      snap;
  logic [GENOME_BITS-1:0] tgt;
  logic [IDX_W-1:0]       idx;
  logic [SCORE_W-1:0]     acc;
  logic [CHUNK_W-1:0]     chunk;
  logic [CHUNK_BITS-1:0]  chunk_match;
  logic [PC_W-1:0]        chunk_cnt;
  logic                   handshake;
  logic                   last_chunk;
  logic                   last_idx;

  assign chunk_match = ~(snap[CHUNK_BITS-1:0] ^ tgt[CHUNK_BITS-1:0]);

  popcount_chunk #(.CHUNK_BITS(CHUNK_BITS)) u_popcount (
    .bits  (chunk_match),
    .count (chunk_cnt)
  );

  assign handshake  = (state == ST_EMIT) && score_ready;
  assign last_chunk = (chunk == CHUNK_W'(NCHUNK - 1));
  assign last_idx   = (idx == IDX_W'(POP_SIZE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (start) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_ACCUM;
      ST_ACCUM: if (last_chunk) state_nxt = ST_EMIT;
      ST_EMIT:  if (handshake) state_nxt = last_idx ? ST_DONE : ST_ACCUM;
      ST_DONE:  if (!start) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // The whole snapshot shifts so the current chunk is always at the LSBs;
  // the target rotates instead, returning to its origin every NCHUNK cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap       <= '0;
      tgt        <= '0;
      idx        <= '0;
      acc        <= '0;
      chunk      <= '0;
      best_index <= '0;
      best_value <= '0;
    end else begin
      unique case (state)
        ST_LOAD: begin
          snap       <= population;
          tgt        <= target;
          idx        <= '0;
          acc        <= '0;
          chunk      <= '0;
          best_index <= '0;
          best_value <= '0;
        end
        ST_ACCUM: begin
          snap  <= snap >> CHUNK_BITS;
          tgt   <= (tgt >> CHUNK_BITS) | (tgt << (GENOME_BITS - CHUNK_BITS));
          acc   <= acc + SCORE_W'(chunk_cnt);
          chunk <= last_chunk ? '0 : chunk + CHUNK_W'(1);
        end
        ST_EMIT: begin
          if (handshake) begin
            if (idx == '0 || acc > best_value) begin
              best_index <= idx;
              best_value <= acc;
            end
            if (!last_idx) begin
              idx <= idx + IDX_W'(1);
              acc <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    score_valid = (state == ST_EMIT);
    score_index = score_valid ? idx : '0;
    score_value = score_valid ? acc : '0;
    busy        = (state == ST_LOAD) || (state == ST_ACCUM) || (state == ST_EMIT);
    done        = (state == ST_DONE);
  end

endmodule
